// File: rtl/gate_truth_table_checker.sv
// Truth-table driver and checker for one N_IN-input logic gate under test.
// Steps dut_in through every vector and compares dut_y against the selected reference.
module gate_truth_table_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       func_sel,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] F_AND  = 3'b000;
   localparam logic [2:0] F_OR   = 3'b001;
   localparam logic [2:0] F_NAND = 3'b010;
   localparam logic [2:0] F_NOR  = 3'b011;
   localparam logic [2:0] F_XOR  = 3'b100;
   localparam logic [2:0] F_XNOR = 3'b101;

   // With no settle time a vector goes straight to its sample cycle.
   localparam state_t        HOLD_STATE  = (SETTLE == 0) ? SAMPLE : APPLY;
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [N_IN:0] VEC_LAST    = {1'b0, {N_IN{1'b1}}};

   state_t           state, state_n;
   logic [N_IN:0]    vec, vec_n;
   logic [3:0]       settle_cnt, settle_cnt_n;
   logic [2:0]       func, func_n;
   logic [N_IN-1:0]  dut_in_n;
   logic [ERR_W-1:0] err_cnt_n;
   logic [N_IN-1:0]  first_err_vec_n;
   logic             first_err_valid_n;
   logic             pass_n;

   logic             exp_y;
   logic             mismatch;
   logic             accept;
   logic             reserved;
   logic [N_IN:0]    vec_inc;

   always_comb begin
      exp_y = 1'b0;
      case (func)
         F_AND:   exp_y =  &vec[N_IN-1:0];
         F_OR:    exp_y =  |vec[N_IN-1:0];
         F_NAND:  exp_y = ~&vec[N_IN-1:0];
         F_NOR:   exp_y = ~|vec[N_IN-1:0];
         F_XOR:   exp_y =  ^vec[N_IN-1:0];
         F_XNOR:  exp_y = ~^vec[N_IN-1:0];
         default: exp_y = 1'b0;
      endcase
   end

   // Case inequality so an unknown gate output is flagged in simulation.
   assign mismatch = (dut_y !== exp_y);
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign reserved = func_sel[2] & func_sel[1];
   assign vec_inc  = vec + 1'b1;

   // NOTE: every next-state variable gets a default before the case, so no
   // path through this block leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_n           = state;
      vec_n             = vec;
      settle_cnt_n      = settle_cnt;
      func_n            = func;
      dut_in_n          = dut_in;
      err_cnt_n         = err_cnt;
      first_err_vec_n   = first_err_vec;
      first_err_valid_n = first_err_valid;
      pass_n            = pass;

      case (state)
         IDLE: begin
            dut_in_n = '0;
         end
         APPLY: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_n = SAMPLE;
            end else begin
               settle_cnt_n = settle_cnt + 4'd1;
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err_cnt != '1) begin
                  err_cnt_n = err_cnt + 1'b1;
               end
               if (!first_err_valid) begin
                  first_err_vec_n   = vec[N_IN-1:0];
                  first_err_valid_n = 1'b1;
               end
            end
            if (vec == VEC_LAST) begin
               state_n = DONE;
               pass_n  = (err_cnt == '0) && !mismatch;
            end else begin
               vec_n        = vec_inc;
               dut_in_n     = vec_inc[N_IN-1:0];
               settle_cnt_n = 4'd0;
               state_n      = HOLD_STATE;
            end
         end
         DONE: begin
            dut_in_n = '0;
            state_n  = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // A start in IDLE or in the DONE cycle opens a fresh run.
      if (accept) begin
         func_n            = func_sel;
         vec_n             = '0;
         settle_cnt_n      = 4'd0;
         dut_in_n          = '0;
         err_cnt_n         = '0;
         first_err_vec_n   = '0;
         first_err_valid_n = 1'b0;
         pass_n            = 1'b0;
         if (reserved) begin
            err_cnt_n = '1;
            state_n   = DONE;
         end else begin
            state_n   = HOLD_STATE;
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // values from before the edge regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec             <= '0;
         settle_cnt      <= 4'd0;
         func            <= 3'd0;
         dut_in          <= '0;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
         pass            <= 1'b0;
      end else begin
         vec             <= vec_n;
         settle_cnt      <= settle_cnt_n;
         func            <= func_n;
         dut_in          <= dut_in_n;
         err_cnt         <= err_cnt_n;
         first_err_vec   <= first_err_vec_n;
         first_err_valid <= first_err_valid_n;
         pass            <= pass_n;
      end
   end

   assign busy = (state == APPLY) || (state == SAMPLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two configurations driven by table-defined gates,
// each checked every cycle against a per-run timeline computed from the gate rules.
module tb_gate_truth_table_checker;

   localparam int NS [2] = '{2, 3};
   localparam int SS [2] = '{1, 0};
   localparam int WS [2] = '{8, 2};

   typedef struct {
      bit busy;
      bit done;
      bit pass;
      bit fval;
      int din;
      int err;
      int fev;
   } snap_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]      start_v;
   logic [1:0][2:0] fsel_v;
   logic [1:0][7:0] tbl_v;

   wire [1:0]      busy_v, done_v, pass_v, fval_v;
   wire [1:0][7:0] din_v, err_v, fev_v;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference gate value from the count of ones in the vector.
   function automatic bit ref_y(input int f, input int n, input int v);
      int pop;
      pop = $countones(v);
      case (f)
         0: return pop == n;
         1: return pop > 0;
         2: return pop != n;
         3: return pop == 0;
         4: return (pop % 2) == 1;
         5: return (pop % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int NI  = NS[gi];
      localparam int ST  = SS[gi];
      localparam int EW  = WS[gi];
      localparam int NV  = 1 << NI;
      localparam int SAT = (1 << EW) - 1;

      logic [NI-1:0] dut_in;
      logic [NI-1:0] fev;
      logic [EW-1:0] err;
      logic          busy, done, pass, fval;
      logic          y;

      assign y = tbl_v[gi][dut_in];

      gate_truth_table_checker #(.N_IN(NI), .SETTLE(ST), .ERR_W(EW)) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .start           (start_v[gi]),
         .func_sel        (fsel_v[gi]),
         .dut_in          (dut_in),
         .dut_y           (y),
         .busy            (busy),
         .done            (done),
         .pass            (pass),
         .err_cnt         (err),
         .first_err_vec   (fev),
         .first_err_valid (fval)
      );

      assign busy_v[gi] = busy;
      assign done_v[gi] = done;
      assign pass_v[gi] = pass;
      assign fval_v[gi] = fval;
      assign din_v[gi]  = 8'(dut_in);
      assign err_v[gi]  = 8'(err);
      assign fev_v[gi]  = 8'(fev);

      snap_t cur;
      snap_t q[$];

      // Expected output for every cycle of one run, plus its DONE cycle.
      task automatic plan_run(input int f, input logic [7:0] t);
         snap_t s;
         bit    m [8];
         int    cnt;
         int    first;
         q.delete();
         s = '{default: 0};
         if (f >= 6) begin
            s.done = 1'b1;
            s.err  = SAT;
            q.push_back(s);
            return;
         end
         for (int v = 0; v < NV; v++) m[v] = (ref_y(f, NI, v) != t[v]);
         for (int c = 0; c <= NV * (ST + 1); c++) begin
            int nd;
            nd = (c == NV * (ST + 1)) ? NV : c / (ST + 1);
            cnt = 0;
            first = -1;
            for (int v = 0; v < nd; v++) begin
               if (m[v]) begin
                  cnt++;
                  if (first < 0) first = v;
               end
            end
            s.err  = (cnt > SAT) ? SAT : cnt;
            s.fval = (first >= 0);
            s.fev  = (first >= 0) ? first : 0;
            if (c < NV * (ST + 1)) begin
               s.busy = 1'b1;
               s.done = 1'b0;
               s.pass = 1'b0;
               s.din  = nd;
            end else begin
               s.busy = 1'b0;
               s.done = 1'b1;
               s.pass = (cnt == 0);
               s.din  = NV - 1;
            end
            q.push_back(s);
         end
      endtask

      initial begin : model
         cur = '{default: 0};
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               q.delete();
               cur = '{default: 0};
            end else begin
               if (start_v[gi] && !cur.busy) plan_run(int'(fsel_v[gi]), tbl_v[gi]);
               if (q.size() > 0) begin
                  cur = q.pop_front();
               end else begin
                  cur.busy = 1'b0;
                  cur.done = 1'b0;
                  cur.din  = 0;
               end
            end
         end
      end

      initial begin : compare
         forever begin
            @(negedge clk);
            check($sformatf("u%0d busy", gi), int'(busy), int'(cur.busy));
            check($sformatf("u%0d done", gi), int'(done), int'(cur.done));
            check($sformatf("u%0d pass", gi), int'(pass), int'(cur.pass));
            check($sformatf("u%0d dut_in", gi), int'(dut_in), cur.din);
            check($sformatf("u%0d err_cnt", gi), int'(err), cur.err);
            check($sformatf("u%0d first_err_valid", gi), int'(fval), int'(cur.fval));
            check($sformatf("u%0d first_err_vec", gi), int'(fev), cur.fev);
         end
      end
   end

   task automatic wait_done(input int i, output int edges);
      edges = 0;
      while (!done_v[i] && edges < 300) begin
         @(negedge clk);
         edges++;
      end
      if (!done_v[i]) check($sformatf("u%0d done timeout", i), int'(done_v[i]), 1);
   endtask

   // One start pulse from idle; returns in the DONE cycle with edges counted after acceptance.
   task automatic run(input int i, input int f, input logic [7:0] t, output int edges);
      @(negedge clk);
      fsel_v[i]  = 3'(f);
      tbl_v[i]   = t;
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      wait_done(i, edges);
   endtask

   initial begin
      int edges;
      int k;
      rst_n   = 1'b0;
      start_v = '0;
      fsel_v  = '0;
      tbl_v   = '0;
      repeat (2) @(negedge clk);
      check("reset busy", int'(busy_v), 0);
      check("reset err_cnt", int'(err_v[0]), 0);
      rst_n = 1'b1;

      // Correct AND gate against AND reference.
      run(0, 0, 8'h08, edges);
      check("and done latency", edges, 8);
      check("and pass", int'(pass_v[0]), 1);
      check("and err_cnt", int'(err_v[0]), 0);
      check("and first_err_valid", int'(fval_v[0]), 0);

      // OR gate against AND reference.
      run(0, 0, 8'h0E, edges);
      check("or-vs-and err_cnt", int'(err_v[0]), 2);
      check("or-vs-and first_err_vec", int'(fev_v[0]), 1);
      check("or-vs-and first_err_valid", int'(fval_v[0]), 1);
      check("or-vs-and pass", int'(pass_v[0]), 0);

      // Output tied low against NAND reference.
      run(0, 2, 8'h00, edges);
      check("nand tied0 err_cnt", int'(err_v[0]), 3);
      check("nand tied0 first_err_vec", int'(fev_v[0]), 0);
      check("nand tied0 pass", int'(pass_v[0]), 0);

      // Reset while vector 10 is applied.
      @(negedge clk);
      fsel_v[0]  = 3'd0;
      tbl_v[0]   = 8'h0E;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      k = 0;
      while (din_v[0] != 8'd2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("midrun reached vector 10", int'(din_v[0]), 2);
      #2 rst_n = 1'b0;
      #1;
      check("midrun reset busy", int'(busy_v[0]), 0);
      check("midrun reset dut_in", int'(din_v[0]), 0);
      check("midrun reset err_cnt", int'(err_v[0]), 0);
      check("midrun reset done", int'(done_v[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 0, 8'h08, edges);
      check("after reset and pass", int'(pass_v[0]), 1);

      // Start held high across two runs.
      @(negedge clk);
      fsel_v[0]  = 3'd0;
      tbl_v[0]   = 8'h08;
      start_v[0] = 1'b1;
      wait_done(0, edges);
      check("held first pass", int'(pass_v[0]), 1);
      @(negedge clk);
      check("held pass cleared", int'(pass_v[0]), 0);
      check("held restarted busy", int'(busy_v[0]), 1);
      wait_done(0, edges);
      start_v[0] = 1'b0;
      @(negedge clk);

      // Narrow counter, zero settle: NOR reference with output tied high.
      run(1, 3, 8'hFF, edges);
      check("nor sat done latency", edges, 8);
      check("nor sat err_cnt", int'(err_v[1]), 3);
      check("nor sat first_err_vec", int'(fev_v[1]), 1);
      check("nor sat pass", int'(pass_v[1]), 0);
      run(1, 7, 8'hFF, edges);
      check("reserved done next cycle", edges, 0);
      check("reserved pass", int'(pass_v[1]), 0);
      check("reserved err_cnt", int'(err_v[1]), 3);
      check("reserved first_err_valid", int'(fval_v[1]), 0);

      // Random gates and reference functions on both configurations.
      for (int r = 0; r < 30; r++) begin
         int        i;
         int        f;
         logic [7:0] t;
         i = int'($urandom_range(0, 1));
         f = int'($urandom_range(0, 7));
         t = 8'($urandom);
         run(i, f, t, edges);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
